// File: rtl/fp_max_reduce_pkg.sv
// Shared FP encodings and FSM state encoding for the FP max-reduction block.
package fp_max_reduce_pkg;

  localparam logic [31:0] FP_NANS  = 32'h7FA0_0000;
  localparam logic [31:0] FP_ZEROP = 32'h0000_0000;
  localparam logic [31:0] FP_ZERON = 32'h8000_0000;
  localparam logic [31:0] FP_INFP  = 32'h7F80_0000;
  localparam logic [31:0] FP_INFN  = 32'hFF80_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_CMP1   = 3'd2,
    ST_CMP2   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/fp_comp.sv
// IEEE-754 comparator with registered great/less/eq/inv flags, captured while act=1.
module fp_comp #(
  parameter int W  = 32,
  parameter int EW = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         great,
  output logic         less,
  output logic         eq,
  output logic         inv
);

  logic         nan1, nan2, g_c, l_c, e_c, n_c;
  logic [W-2:0] mag1, mag2;

  assign mag1 = in1[W-2:0];
  assign mag2 = in2[W-2:0];
  assign nan1 = (&in1[W-2:W-1-EW]) && (|in1[W-2-EW:0]);
  assign nan2 = (&in2[W-2:W-1-EW]) && (|in2[W-2-EW:0]);

  // Sign-magnitude ordering; +0 and -0 compare equal.
  always_comb begin
    g_c = 1'b0;
    l_c = 1'b0;
    e_c = 1'b0;
    n_c = 1'b0;
    if (nan1 || nan2) begin
      n_c = 1'b1;
    end else if ((mag1 == '0 && mag2 == '0) || in1 == in2) begin
      e_c = 1'b1;
    end else if (in1[W-1] != in2[W-1]) begin
      g_c = ~in1[W-1];
      l_c = in1[W-1];
    end else if (!in1[W-1]) begin
      g_c = (mag1 > mag2);
      l_c = ~g_c;
    end else begin
      g_c = (mag1 < mag2);
      l_c = ~g_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      great <= 1'b0;
      less  <= 1'b0;
      eq    <= 1'b0;
      inv   <= 1'b0;
    end else if (act) begin
      great <= g_c;
      less  <= l_c;
      eq    <= e_c;
      inv   <= n_c;
    end
  end

endmodule

// File: rtl/fp_max_reduce.sv
// Streaming FP maximum reduction; optional running minimum via FP_REDUCE_MIN_EN.
//
// state  | meaning
// IDLE   | waiting for first element of a stream (in_ready=1)
// ACCEPT | waiting for next element (in_ready=1)
// CMP1   | candidate vs max presented, comparator capturing
// CMP2   | comparator flags valid, max/inv updated at end
// DONE   | result held with out_valid=1 until out_ready
module fp_max_reduce
  import fp_max_reduce_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [W-1:0]     out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_inv,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FP_REDUCE_MIN_EN
  ,output logic [W-1:0]    out_min
`endif
);

  state_e           state_q, state_d;
  logic [W-1:0]     max_q, cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inv_q, last_q;
  logic             xfer, cmp_act;
  logic             c_great, c_less, c_eq, c_inv;

  assign xfer = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cmp_act   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_last ? ST_DONE : ST_ACCEPT;
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_CMP1;
      end
      ST_CMP1: begin
        cmp_act = 1'b1;
        state_d = ST_CMP2;
      end
      ST_CMP2: begin
        cmp_act = 1'b1;
        state_d = last_q ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  fp_comp #(.W(W)) u_comp (
    .clk   (clk),
    .rst   (rst),
    .act   (cmp_act),
    .in1   (cand_q),
    .in2   (max_q),
    .great (c_great),
    .less  (c_less),
    .eq    (c_eq),
    .inv   (c_inv)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q  <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && xfer) begin
        max_q <= in_data;
        cnt_q <= CNT_W'(1);
        inv_q <= 1'b0;
      end else if (state_q == ST_ACCEPT && xfer) begin
        cand_q <= in_data;
        last_q <= in_last;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == ST_CMP2) begin
        // An unordered compare flags invalid and never moves the maximum.
        if (c_inv)        inv_q <= 1'b1;
        else if (c_great) max_q <= cand_q;
      end
    end
  end

`ifdef FP_REDUCE_MIN_EN
  logic [W-1:0] min_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q <= '0;
    end else if (state_q == ST_IDLE && xfer) begin
      min_q <= in_data;
    end else if (state_q == ST_CMP2 && !c_inv && c_less) begin
      min_q <= cand_q;
    end
  end

  assign out_min = min_q;
`endif

  assign out_max   = max_q;
  assign out_count = cnt_q;
  assign out_inv   = inv_q;

  logic unused_eq;
  assign unused_eq = c_eq;

endmodule

// File: tb/tb_fp_max_reduce.sv
// Directed, table-driven bench for fp_max_reduce (small counter to reach saturation).
module tb_fp_max_reduce;
  import fp_max_reduce_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     in_data;
  logic             in_valid, in_last, in_ready;
  logic [W-1:0]     out_max;
  logic [CNT_W-1:0] out_count;
  logic             out_inv, out_valid, out_ready;
`ifdef FP_REDUCE_MIN_EN
  logic [W-1:0]     out_min;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_max_reduce #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_max   (out_max),
    .out_count (out_count),
    .out_inv   (out_inv),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FP_REDUCE_MIN_EN
    ,.out_min  (out_min)
`endif
  );

  typedef struct {
    int          n;
    logic [31:0] d0, d1, d2, d3;
    logic [31:0] emax;
    logic [31:0] emin;
    int          ecnt;
    logic        einv;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(int n, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                              logic [31:0] d, logic [31:0] emax, logic [31:0] emin,
                              int ecnt, logic einv);
    vec_t v;
    v.n = n; v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
    v.emax = emax; v.emin = emin; v.ecnt = ecnt; v.einv = einv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] elem(vec_t v, int i);
    case (i)
      0: return v.d0;
      1: return v.d1;
      2: return v.d2;
      default: return v.d3;
    endcase
  endfunction

  initial begin
    vecs[0] = mk(3, 32'h3F800000, 32'h40400000, 32'h40000000, 0,
                 32'h40400000, 32'h3F800000, 3, 1'b0);
    vecs[1] = mk(1, 32'hC0A00000, 0, 0, 0,
                 32'hC0A00000, 32'hC0A00000, 1, 1'b0);
    vecs[2] = mk(3, 32'h3F800000, FP_NANS, 32'h3F000000, 0,
                 32'h3F800000, 32'h3F000000, 3, 1'b1);
    vecs[3] = mk(2, FP_ZERON, FP_ZEROP, 0, 0,
                 FP_ZERON, FP_ZERON, 2, 1'b0);
    vecs[4] = mk(4, 32'hBF800000, 32'hC0000000, FP_INFN, FP_INFP,
                 FP_INFP, FP_INFN, 4, 1'b0);
    vecs[5] = mk(3, 32'h40000000, 32'hC0A00000, 32'h3F800000, 0,
                 32'h40000000, 32'hC0A00000, 3, 1'b0);
    vecs[6] = mk(2, 32'hC0400000, 32'hC0000000, 0, 0,
                 32'hC0000000, 32'hC0400000, 2, 1'b0);
    vecs[7] = mk(2, FP_NANS, 32'h3F800000, 0, 0,
                 FP_NANS, FP_NANS, 2, 1'b1);

    rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_max", out_max, 32'd0);
    chk("rst_count", {29'd0, out_count}, 32'd0);
    chk("rst_inv", {31'd0, out_inv}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < vecs[t].n; i++)
        send(elem(vecs[t], i), (i == vecs[t].n - 1));
      if (vecs[t].n == 1) chk($sformatf("v%0d_latency", t), {31'd0, out_valid}, 32'd1);
      wait_done();
      chk($sformatf("v%0d_max", t), out_max, vecs[t].emax);
      chk($sformatf("v%0d_count", t), {29'd0, out_count}, vecs[t].ecnt);
      chk($sformatf("v%0d_inv", t), {31'd0, out_inv}, {31'd0, vecs[t].einv});
      chk($sformatf("v%0d_in_ready", t), {31'd0, in_ready}, 32'd0);
`ifdef FP_REDUCE_MIN_EN
      chk($sformatf("v%0d_min", t), out_min, vecs[t].emin);
`endif
      release_done();
    end

    // DONE held for 5 cycles with out_ready low.
    send(32'h3F800000, 1'b0);
    send(32'h40400000, 1'b1);
    wait_done();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_max", out_max, 32'h40400000);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    release_done();

    // Cadence: one element per 3 cycles, then counter saturation at 7.
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    chk("cmp1_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("cmp2_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 2; i < 9; i++)
      send(32'h3F800000 + (i << 23), (i == 8));
    wait_done();
    chk("sat_count", {29'd0, out_count}, 32'd7);
    chk("sat_max", out_max, 32'h43800000);
    release_done();

    // Asynchronous reset while in CMP1.
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_max", out_max, 32'd0);
    chk("midrst_count", {29'd0, out_count}, 32'd0);
    chk("midrst_inv", {31'd0, out_inv}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
`ifdef FP_REDUCE_MIN_EN
    chk("midrst_min", out_min, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'hC0A00000, 1'b1);
    chk("postrst_valid", {31'd0, out_valid}, 32'd1);
    chk("postrst_max", out_max, 32'hC0A00000);
    chk("postrst_count", {29'd0, out_count}, 32'd1);
    release_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fp_max_reduce.md
FP_MAX_REDUCE -- requirements
Module: fp_max_reduce

Interface
REQ-001 SHALL provide parameter W, default 32, FP operand width (IEEE-754 single).
REQ-002 SHALL provide parameter CNT_W, default 16, element-counter width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_data, input, W, stream element.
REQ-006 SHALL have port in_valid, input, 1, in_data valid.
REQ-007 SHALL have port in_last, input, 1, final element of current stream.
REQ-008 SHALL have port in_ready, output, 1, block accepts element.
REQ-009 SHALL have port out_max, output, W, running/final maximum.
REQ-010 SHALL have port out_count, output, CNT_W, elements accepted.
REQ-011 SHALL have port out_inv, output, 1, sticky invalid-compare flag.
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer takes result.

Function
REQ-014 SHALL implement FSM states IDLE, ACCEPT, CMP1, CMP2, DONE.
REQ-015 SHALL assert in_ready only in IDLE and ACCEPT; transfer = in_valid && in_ready at clk edge.
REQ-016 IDLE transfer: max <= in_data, count <= 1, inv <= 0; next DONE if in_last else ACCEPT.
REQ-017 ACCEPT transfer: capture candidate and last flag, count++; next CMP1.
REQ-018 CMP1/CMP2 SHALL present in1=candidate, in2=max to comparator, held stable both cycles (act=1).
REQ-019 End of CMP2 SHALL sample registered comparator outputs: great=1 -> max <= candidate; eq or less -> max unchanged (first-seen kept, +0/-0 equal).
REQ-020 inv=1 at CMP2 SHALL set out_inv and leave max unchanged, irrespective of great/less/eq.
REQ-021 After CMP2: next DONE if captured last, else ACCEPT; sustained throughput one element per 3 cycles.
REQ-022 DONE SHALL hold out_valid=1 and all outputs stable until out_ready=1; then next IDLE.
REQ-023 out_valid SHALL be 0 in every state except DONE; out_ready ignored outside DONE.
REQ-024 out_count SHALL saturate at 2^CNT_W-1, no wrap.
REQ-025 out_max, out_count, out_inv SHALL be registered and visible in every state.

Reset
REQ-026 rst low SHALL force IDLE, out_max=0, out_count=0, out_inv=0, out_valid=0, candidate cleared, asynchronously, including mid-CMP or DONE.
REQ-027 First element after reset release SHALL be acceptable on first rising edge with rst high.

Configuration
REQ-028 Macro FP_REDUCE_MIN_EN defined: SHALL add output out_min (W), reset 0, loaded in IDLE, updated in CMP2 on less=1 with inv=0, same compare reused.
REQ-029 Macro undefined: out_min port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-030 FP special encodings (FP_NANS, FP_ZEROP, FP_ZERON, FP_INFP, FP_INFN) and FSM state encoding SHALL live in the shared FP package/include.
REQ-031 SHALL instantiate exactly one sub-module, fp_comp, as the comparator; no other compare logic.

Verification
REQ-032 Stream 0x3F800000, 0x40400000, 0x40000000(last) -> out_max=0x40400000, out_count=3, out_inv=0, out_valid in DONE.
REQ-033 Single element 0xC0A00000 with in_last -> DONE next cycle, out_max=0xC0A00000, out_count=1.
REQ-034 Stream 0x3F800000, FP_NANS, 0x3F000000(last) -> out_max=0x3F800000, out_inv=1, out_count=3.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid, out_max stable, in_ready=0; release -> IDLE next cycle.
REQ-036 rst low during CMP1 -> all outputs 0 immediately, IDLE, in_ready=1 after release.
REQ-037 FP_REDUCE_MIN_EN: stream 0x40000000, 0xC0A00000, 0x3F800000(last) -> out_min=0xC0A00000, out_max=0x40000000.
